route_traceback: RTL and testbench

ROUTE_TRACEBACK -- requirements
Module: route_traceback

---
 rtl/route_traceback.sv | 176 +++++++++++++++++
 tb/tb_route_traceback.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_traceback.sv
`default_nettype none
// ============================================================================
// route_traceback : walks active edges from end_point back to start_point,
//                   streaming each point of the recovered path.
// Revision: 1.0
// ============================================================================
module route_traceback #(
  parameter  int N_EDGES  = 1024,
  parameter  int PT_W     = 8,
  parameter  int MAX_HOPS = 64,
  localparam int IDX_W    = (N_EDGES > 1) ? $clog2(N_EDGES) : 1,
  localparam int HOP_W    = $clog2(MAX_HOPS + 1),
  localparam int N_PTS    = 2 ** PT_W
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               start,
  input  logic [PT_W-1:0]    start_point,
  input  logic [PT_W-1:0]    end_point,
  input  logic [N_EDGES-1:0] active_route,
  output logic               edge_rd_en,
  output logic [IDX_W-1:0]   edge_rd_idx,
  input  logic [PT_W-1:0]    edge_rd_a,
  input  logic [PT_W-1:0]    edge_rd_b,
  output logic               path_valid,
  input  logic               path_ready,
  output logic [PT_W-1:0]    path_point,
  output logic               path_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, EMIT, SCAN, FINISH, FAIL} state_e;

  state_e             state_q, state_d;
  logic [PT_W-1:0]    cur_q, cur_d, start_q, start_d;
  logic [N_EDGES-1:0] route_q, route_d;
  logic [N_PTS-1:0]   visited_q, visited_d;
  logic [HOP_W-1:0]   hop_q, hop_d;
  logic [IDX_W-1:0]   idx_q, idx_d, eval_idx_q, eval_idx_d;
  logic               issued_all_q, issued_all_d;
  logic               eval_vld_q, eval_vld_d;

  logic               is_last, last_idx, match;
  logic [PT_W-1:0]    other;
  logic [HOP_W-1:0]   hop_inc;

  assign is_last     = (cur_q == start_q);
  assign last_idx    = (idx_q == IDX_W'(N_EDGES - 1));
  assign hop_inc     = hop_q + HOP_W'(1);
  assign edge_rd_idx = idx_q;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      start_q      <= '0;
      route_q      <= '0;
      visited_q    <= '0;
      hop_q        <= '0;
      idx_q        <= '0;
      eval_idx_q   <= '0;
      issued_all_q <= 1'b0;
      eval_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      start_q      <= start_d;
      route_q      <= route_d;
      visited_q    <= visited_d;
      hop_q        <= hop_d;
      idx_q        <= idx_d;
      eval_idx_q   <= eval_idx_d;
      issued_all_q <= issued_all_d;
      eval_vld_q   <= eval_vld_d;
    end
  end

  // Edge data returned this cycle belongs to eval_idx_q, issued one cycle earlier.
  always_comb begin
    match = 1'b0;
    other = edge_rd_b;
    if (eval_vld_q && route_q[eval_idx_q] && (edge_rd_a != edge_rd_b)) begin
      if ((edge_rd_a == cur_q) && !visited_q[edge_rd_b]) begin
        match = 1'b1;
        other = edge_rd_b;
      end else if ((edge_rd_b == cur_q) && !visited_q[edge_rd_a]) begin
        match = 1'b1;
        other = edge_rd_a;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    start_d      = start_q;
    route_d      = route_q;
    visited_d    = visited_q;
    hop_d        = hop_q;
    idx_d        = idx_q;
    eval_idx_d   = eval_idx_q;
    issued_all_d = issued_all_q;
    eval_vld_d   = eval_vld_q;
    path_valid   = 1'b0;
    path_point   = '0;
    path_last    = 1'b0;
    edge_rd_en   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          start_d              = start_point;
          cur_d                = end_point;
          route_d              = active_route;
          visited_d            = '0;
          visited_d[end_point] = 1'b1;
          hop_d                = '0;
          state_d              = EMIT;
        end
      end
      EMIT: begin
        busy       = 1'b1;
        path_valid = 1'b1;
        path_point = cur_q;
        path_last  = is_last;
        if (path_ready) begin
          hop_d = hop_inc;
          if (is_last) begin
            state_d = FINISH;
          end else if (hop_inc == HOP_W'(MAX_HOPS)) begin
            state_d = FAIL;
          end else begin
            state_d      = SCAN;
            idx_d        = '0;
            issued_all_d = 1'b0;
            eval_vld_d   = 1'b0;
          end
        end
      end
      SCAN: begin
        busy       = 1'b1;
        edge_rd_en = !issued_all_q;
        eval_vld_d = !issued_all_q;
        eval_idx_d = idx_q;
        if (!issued_all_q) begin
          if (last_idx) issued_all_d = 1'b1;
          else          idx_d        = idx_q + IDX_W'(1);
        end
        if (match) begin
          cur_d            = other;
          visited_d[other] = 1'b1;
          eval_vld_d       = 1'b0;
          state_d          = EMIT;
        end else if (eval_vld_q && (eval_idx_q == IDX_W'(N_EDGES - 1))) begin
          state_d = FAIL;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_route_traceback.sv
`default_nettype none
// ============================================================================
// tb_route_traceback : directed scoreboard bench for route_traceback with a
//                      one-cycle-latency edge table model.
// Revision: 1.0
// ============================================================================
module tb_route_traceback;

  localparam int N_EDGES  = 16;
  localparam int PT_W     = 4;
  localparam int MAX_HOPS = 4;
  localparam int IDX_W    = 4;

  typedef struct {
    int pt;
    int last;
  } beat_t;

  logic               CLK = 1'b0;
  logic               RST_n = 1'b0;
  logic               start = 1'b0;
  logic [PT_W-1:0]    start_point = '0;
  logic [PT_W-1:0]    end_point = '0;
  logic [N_EDGES-1:0] active_route = '0;
  logic               edge_rd_en;
  logic [IDX_W-1:0]   edge_rd_idx;
  logic [PT_W-1:0]    edge_rd_a = '0;
  logic [PT_W-1:0]    edge_rd_b = '0;
  logic               path_valid;
  logic               path_ready = 1'b1;
  logic [PT_W-1:0]    path_point;
  logic               path_last;
  logic               busy, done, err;

  logic [PT_W-1:0] tbl_a [N_EDGES];
  logic [PT_W-1:0] tbl_b [N_EDGES];

  beat_t sb[$];
  beat_t e;

  int checks = 0, failures = 0;
  int cyc = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, beats = 0, xfer_cyc = 0;
  int prev_rd_en = 0, prev_rd_idx = 0;
  int stalled = 0, hold_pt = 0, hold_last = 0;
  bit toggle_rdy = 1'b0;

  route_traceback #(
    .N_EDGES (N_EDGES),
    .PT_W    (PT_W),
    .MAX_HOPS(MAX_HOPS)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .start       (start),
    .start_point (start_point),
    .end_point   (end_point),
    .active_route(active_route),
    .edge_rd_en  (edge_rd_en),
    .edge_rd_idx (edge_rd_idx),
    .edge_rd_a   (edge_rd_a),
    .edge_rd_b   (edge_rd_b),
    .path_valid  (path_valid),
    .path_ready  (path_ready),
    .path_point  (path_point),
    .path_last   (path_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (edge_rd_en) begin
      edge_rd_a <= tbl_a[edge_rd_idx];
      edge_rd_b <= tbl_b[edge_rd_idx];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: read-index sequencing, stall stability and scoreboard pops.
  always @(negedge CLK) begin
    if (edge_rd_en) begin
      rd_cnt++;
      chk("rd_idx_seq", int'(edge_rd_idx), (prev_rd_en != 0) ? prev_rd_idx + 1 : 0);
    end
    prev_rd_en  = int'(edge_rd_en);
    prev_rd_idx = int'(edge_rd_idx);
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (path_valid) begin
      if (stalled != 0) begin
        chk("stall_point", int'(path_point), hold_pt);
        chk("stall_last", int'(path_last), hold_last);
      end
      if (path_ready) begin
        beats++;
        xfer_cyc = cyc + 1;
        stalled  = 0;
        if (sb.size() == 0) begin
          chk("beat_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("beat_point", int'(path_point), e.pt);
          chk("beat_last", int'(path_last), e.last);
        end
      end else begin
        stalled   = 1;
        hold_pt   = int'(path_point);
        hold_last = int'(path_last);
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic push(input int pt, input int last);
    beat_t b;
    b.pt   = pt;
    b.last = last;
    sb.push_back(b);
  endtask

  task automatic clear_table();
    for (int i = 0; i < N_EDGES; i++) begin
      tbl_a[i] = '0;
      tbl_b[i] = '0;
    end
  endtask

  task automatic set_edge(input int k, input int a, input int b);
    tbl_a[k] = PT_W'(a);
    tbl_b[k] = PT_W'(b);
  endtask

  task automatic chk_reset();
    chk("rst_path_valid", int'(path_valid), 0);
    chk("rst_path_last", int'(path_last), 0);
    chk("rst_path_point", int'(path_point), 0);
    chk("rst_edge_rd_en", int'(edge_rd_en), 0);
    chk("rst_edge_rd_idx", int'(edge_rd_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
  endtask

  // active_route is scrambled after the start cycle: only the latched copy may matter.
  task automatic do_start(input int sp, input int ep, input logic [N_EDGES-1:0] route);
    @(posedge CLK); #1;
    start        = 1'b1;
    start_point  = PT_W'(sp);
    end_point    = PT_W'(ep);
    active_route = route;
    @(posedge CLK); #1;
    start        = 1'b0;
    active_route = '1;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_term(input int budget, output int kind, output int tcyc);
    kind = 0;
    tcyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK); #1;
      if (done) begin kind = 1; tcyc = cyc; break; end
      if (err)  begin kind = 2; tcyc = cyc; break; end
      if (toggle_rdy) path_ready = ~path_ready;
    end
  endtask

  initial begin
    int kind, tcyc, r0, b0, dc, ec;

    clear_table();
    set_edge(1, 3, 8);
    set_edge(5, 3, 7);
    set_edge(9, 7, 2);
    set_edge(12, 3, 11);

    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset();
    RST_n = 1'b1;

    // Chain 3-e5-7-e9-2, ready held high
    push(3, 0); push(7, 0); push(2, 1);
    r0 = rd_cnt;
    do_start(2, 3, 16'h1220);
    wait_term(200, kind, tcyc);
    chk("t1_term", kind, 1);
    chk("t1_done_timing", tcyc, xfer_cyc);
    chk("t1_reads", rd_cnt - r0, 18);
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Same chain with backpressure toggling
    path_ready = 1'b0;
    toggle_rdy = 1'b1;
    push(3, 0); push(7, 0); push(2, 1);
    r0 = rd_cnt;
    do_start(2, 3, 16'h1220);
    wait_term(300, kind, tcyc);
    toggle_rdy = 1'b0;
    path_ready = 1'b1;
    chk("t2_term", kind, 1);
    chk("t2_done_timing", tcyc, xfer_cyc);
    chk("t2_reads", rd_cnt - r0, 18);
    chk("t2_sb_empty", sb.size(), 0);

    // start_point == end_point
    push(5, 1);
    r0 = rd_cnt;
    do_start(5, 5, 16'h1220);
    wait_term(50, kind, tcyc);
    chk("t3_term", kind, 1);
    chk("t3_done_timing", tcyc, xfer_cyc);
    chk("t3_reads", rd_cnt - r0, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // Unreachable target
    push(13, 0);
    r0 = rd_cnt;
    b0 = beats;
    do_start(2, 13, 16'h1220);
    wait_term(200, kind, tcyc);
    chk("t4_term", kind, 2);
    chk("t4_err_timing", tcyc, xfer_cyc + N_EDGES + 1);
    chk("t4_reads", rd_cnt - r0, N_EDGES);
    chk("t4_beats", beats - b0, 1);
    chk("t4_busy_end", int'(busy), 0);
    chk("t4_sb_empty", sb.size(), 0);

    clear_table();
    set_edge(3, 1, 2);
    set_edge(4, 2, 3);
    set_edge(5, 3, 4);
    set_edge(6, 3, 1);
    set_edge(7, 4, 5);

    // Cycle 1-2-3-1, start_point unreachable
    push(1, 0); push(2, 0); push(3, 0);
    r0 = rd_cnt;
    b0 = beats;
    do_start(9, 1, 16'h0058);
    wait_term(300, kind, tcyc);
    chk("t5_term", kind, 2);
    chk("t5_beats", beats - b0, 3);
    chk("t5_reads", rd_cnt - r0, 27);
    chk("t5_sb_empty", sb.size(), 0);

    // Hop limit reached without start_point
    push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    r0 = rd_cnt;
    b0 = beats;
    do_start(5, 1, 16'h00B8);
    wait_term(200, kind, tcyc);
    chk("t6_term", kind, 2);
    chk("t6_err_timing", tcyc, xfer_cyc);
    chk("t6_beats", beats - b0, 4);
    chk("t6_reads", rd_cnt - r0, 18);
    chk("t6_sb_empty", sb.size(), 0);

    // Path of exactly MAX_HOPS points
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    do_start(4, 1, 16'h00B8);
    wait_term(200, kind, tcyc);
    chk("t7_term", kind, 1);
    chk("t7_done_timing", tcyc, xfer_cyc);
    chk("t7_sb_empty", sb.size(), 0);

    // Reset during SCAN, then a fresh traceback
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    b0 = beats;
    do_start(4, 1, 16'h00B8);
    for (int i = 0; i < 20 && beats == b0; i++) begin
      @(posedge CLK); #1;
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("t8_in_scan", int'(edge_rd_en), 1);
    dc = done_cnt;
    ec = err_cnt;
    RST_n = 1'b0;
    @(posedge CLK); #1;
    chk_reset();
    RST_n = 1'b1;
    sb.delete();
    repeat (3) @(posedge CLK);
    #1;
    chk("t8_no_done", done_cnt - dc, 0);
    chk("t8_no_err", err_cnt - ec, 0);
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    do_start(4, 1, 16'h00B8);
    wait_term(200, kind, tcyc);
    chk("t8_term", kind, 1);
    chk("t8_done_timing", tcyc, xfer_cyc);
    chk("t8_sb_empty", sb.size(), 0);

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
